// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: operation codes, FSM states and
// small decode helpers used by the top level.
package alu_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SLTU  = 4'b1000;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_XOR   = 4'b1101;
  localparam logic [3:0] OP_MULT  = 4'b1001;
  localparam logic [3:0] OP_MULTU = 4'b1010;
  localparam logic [3:0] OP_DIV   = 4'b1011;
  localparam logic [3:0] OP_DIVU  = 4'b1110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  function automatic logic is_multi_op(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Unsigned iterative engine: one shift-add multiply or restoring-divide step
// per cycle on magnitude operands; sign handling lives in the parent.
module alu_muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             run,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a_mag,
  input  logic [WIDTH-1:0] b_mag,
  output logic [WIDTH-1:0] hi_mag,
  output logic [WIDTH-1:0] lo_mag,
  output logic             last
);

  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]    cnt;
  logic             div_mode;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   shl_rem;
  logic [WIDTH-1:0] sub_diff;
  logic             sub_ok;
  logic [WIDTH-1:0] hi_nxt;
  logic [WIDTH-1:0] lo_nxt;

  assign last   = run && (cnt == CW'(WIDTH - 1));
  assign hi_mag = hi_r;
  assign lo_mag = lo_r;

  // Multiply keeps {hi,lo} as partial product / remaining multiplier and
  // shifts right; divide keeps hi as remainder and shifts quotient bits into lo.
  always_comb begin
    add_sum  = {1'b0, hi_r} + (lo_r[0] ? {1'b0, b_r} : '0);
    shl_rem  = {hi_r, lo_r[WIDTH-1]};
    sub_ok   = (shl_rem >= {1'b0, b_r});
    sub_diff = shl_rem[WIDTH-1:0] - b_r;
    if (div_mode) begin
      hi_nxt = sub_ok ? sub_diff : shl_rem[WIDTH-1:0];
      lo_nxt = {lo_r[WIDTH-2:0], sub_ok};
    end else begin
      hi_nxt = add_sum[WIDTH:1];
      lo_nxt = {add_sum[0], lo_r[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= last ? '0 : cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      hi_r     <= '0;
      lo_r     <= a_mag;
      b_r      <= b_mag;
      div_mode <= is_div;
    end else if (run) begin
      hi_r <= hi_nxt;
      lo_r <= lo_nxt;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arithmetic ops plus iterative signed and
// unsigned multiply/divide writing hi/lo through an IDLE/CALC/FIX FSM.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] din1_alu,
  input  logic [WIDTH-1:0] din2_alu,
  output logic [WIDTH-1:0] result_alu,
  output logic             ZF,
  output logic             OF,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_t state;
  state_t state_nxt;

  logic               accept;
  logic               multi_op;
  logic               div_zero;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   diff;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_of;

  logic               res_neg;
  logic               rem_neg;
  logic               dz_r;
  logic               is_div_r;
  logic [WIDTH-1:0]   dividend_r;

  logic [WIDTH-1:0]   hi_mag;
  logic [WIDTH-1:0]   lo_mag;
  logic               iter_last;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   hi_fix;
  logic [WIDTH-1:0]   lo_fix;

  function automatic logic [WIDTH-1:0] neg_if(input logic neg, input logic [WIDTH-1:0] v);
    return neg ? ((~v) + WIDTH'(1)) : v;
  endfunction

  assign busy     = (state != IDLE);
  assign accept   = start && (state == IDLE);
  assign multi_op = is_multi_op(op);
  assign div_zero = is_div_op(op) && (din2_alu == '0);
  assign a_neg    = is_signed_op(op) && din1_alu[WIDTH-1];
  assign b_neg    = is_signed_op(op) && din2_alu[WIDTH-1];
  assign a_mag    = neg_if(a_neg, din1_alu);
  assign b_mag    = neg_if(b_neg, din2_alu);
  assign a_s      = din1_alu;
  assign b_s      = din2_alu;
  assign sum      = din1_alu + din2_alu;
  assign diff     = din1_alu - din2_alu;

  always_comb begin
    alu_res = '0;
    alu_of  = 1'b0;
    case (op)
      OP_AND:  alu_res = din1_alu & din2_alu;
      OP_OR:   alu_res = din1_alu | din2_alu;
      OP_NOR:  alu_res = ~(din1_alu | din2_alu);
      OP_XOR:  alu_res = din1_alu ^ din2_alu;
      OP_ADD: begin
        alu_res = sum;
        alu_of  = (din1_alu[WIDTH-1] == din2_alu[WIDTH-1]) && (sum[WIDTH-1] != din1_alu[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_of  = (din1_alu[WIDTH-1] != din2_alu[WIDTH-1]) && (diff[WIDTH-1] != din1_alu[WIDTH-1]);
      end
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (din1_alu < din2_alu)};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept && multi_op) state_nxt = div_zero ? FIX : CALC;
      CALC: if (iter_last) state_nxt = FIX;
      FIX:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Accept boundary: capture sign bookkeeping for the FIX stage.
  always_ff @(posedge clk) begin
    if (accept && multi_op) begin
      res_neg    <= a_neg ^ b_neg;
      rem_neg    <= a_neg;
      dz_r       <= div_zero;
      is_div_r   <= is_div_op(op);
      dividend_r <= din1_alu;
    end
  end

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .load   (accept && multi_op && !div_zero),
    .run    (state == CALC),
    .is_div (is_div_op(op)),
    .a_mag  (a_mag),
    .b_mag  (b_mag),
    .hi_mag (hi_mag),
    .lo_mag (lo_mag),
    .last   (iter_last)
  );

  // FIX boundary: restore signs on the magnitude results.
  always_comb begin
    prod   = {hi_mag, lo_mag};
    hi_fix = '0;
    lo_fix = '0;
    if (dz_r) begin
      hi_fix = dividend_r;
      lo_fix = '1;
    end else if (is_div_r) begin
      hi_fix = neg_if(rem_neg, hi_mag);
      lo_fix = neg_if(res_neg, lo_mag);
    end else begin
      if (res_neg) prod = -prod;
      hi_fix = prod[2*WIDTH-1:WIDTH];
      lo_fix = prod[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_alu <= '0;
      ZF         <= 1'b1;
      OF         <= 1'b0;
      done       <= 1'b0;
      hi         <= '0;
      lo         <= '0;
    end else begin
      done <= 1'b0;
      if (state == FIX) begin
        hi         <= hi_fix;
        lo         <= lo_fix;
        result_alu <= lo_fix;
        ZF         <= (lo_fix == '0);
        OF         <= 1'b0;
        done       <= 1'b1;
      end else if (accept && !multi_op) begin
        result_alu <= alu_res;
        ZF         <= (alu_res == '0);
        OF         <= alu_of;
        done       <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed vectors push expected responses,
// a negedge monitor pops and compares on every done pulse (WIDTH 32 and 8).
module tb_alu_seq;
  import alu_pkg::*;

  typedef struct {
    logic [31:0] res;
    logic        zf;
    logic        of;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
    int          t0;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, start8;
  logic [3:0]  op, op8;
  logic [31:0] din1, din2, result_alu, hi, lo;
  logic [7:0]  din1_8, din2_8, result8, hi8, lo8;
  logic        ZF, OF, busy, done, ZF8, OF8, busy8, done8;

  exp_t q[$];
  exp_t q8[$];
  exp_t mon_e;
  logic [31:0] exp_hi = '0, exp_lo = '0, exp_hi8 = '0, exp_lo8 = '0;
  int ncyc = 0, checks = 0, errors = 0, done_cnt = 0, dc;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(32)) u_dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .din1_alu(din1), .din2_alu(din2),
    .result_alu(result_alu), .ZF(ZF), .OF(OF), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  alu_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .din1_alu(din1_8), .din2_alu(din2_8),
    .result_alu(result8), .ZF(ZF8), .OF(OF8), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, expv);
    end
  endtask

  always @(negedge clk) begin
    ncyc = ncyc + 1;
    if (done) begin
      done_cnt = done_cnt + 1;
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL done_unexpected: got done=1 at cycle %0d expected no done", ncyc);
      end else begin
        mon_e = q.pop_front();
        chk("result", result_alu, mon_e.res);
        chk("ZF", 32'(ZF), 32'(mon_e.zf));
        chk("OF", 32'(OF), 32'(mon_e.of));
        chk("hi", hi, mon_e.hi);
        chk("lo", lo, mon_e.lo);
        chk("latency", 32'(ncyc - mon_e.t0), 32'(mon_e.lat));
      end
    end
    if (done8) begin
      if (q8.size() == 0) begin
        checks++; errors++;
        $display("FAIL done8_unexpected: got done=1 at cycle %0d expected no done", ncyc);
      end else begin
        mon_e = q8.pop_front();
        chk("result8", 32'(result8), mon_e.res);
        chk("ZF8", 32'(ZF8), 32'(mon_e.zf));
        chk("OF8", 32'(OF8), 32'(mon_e.of));
        chk("hi8", 32'(hi8), mon_e.hi);
        chk("lo8", 32'(lo8), mon_e.lo);
        chk("latency8", 32'(ncyc - mon_e.t0), 32'(mon_e.lat));
      end
    end
  end

  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic eof, input logic multi,
                       input logic [31:0] ehi, input logic [31:0] elo, input int lat);
    exp_t e;
    @(negedge clk); #1;
    op = o; din1 = a; din2 = b; start = 1'b1;
    if (multi) begin exp_hi = ehi; exp_lo = elo; end
    e.res = er; e.zf = (er == 32'd0); e.of = eof; e.hi = exp_hi; e.lo = exp_lo;
    e.lat = lat; e.t0 = ncyc;
    q.push_back(e);
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic issue8(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] er, input logic eof, input logic multi,
                        input logic [7:0] ehi, input logic [7:0] elo, input int lat);
    exp_t e;
    @(negedge clk); #1;
    op8 = o; din1_8 = a; din2_8 = b; start8 = 1'b1;
    if (multi) begin exp_hi8 = 32'(ehi); exp_lo8 = 32'(elo); end
    e.res = 32'(er); e.zf = (er == 8'd0); e.of = eof; e.hi = exp_hi8; e.lo = exp_lo8;
    e.lat = lat; e.t0 = ncyc;
    q8.push_back(e);
    @(negedge clk); #1;
    start8 = 1'b0;
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while ((q.size() != 0 || q8.size() != 0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0 || q8.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d/%0d pending expected 0", q.size(), q8.size());
      q.delete(); q8.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; start8 = 1'b0;
    op = '0; din1 = '0; din2 = '0; op8 = '0; din1_8 = '0; din2_8 = '0;
    repeat (3) @(negedge clk);
    chk("rst_result", result_alu, 32'd0);
    chk("rst_ZF", 32'(ZF), 32'd1);
    chk("rst_OF", 32'(OF), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_ZF8", 32'(ZF8), 32'd1);
    rst = 1'b0;

    // Single-cycle ops
    issue(OP_ADD,  32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b1, 1'b0, 0, 0, 1); drain(10);
    issue(OP_SUB,  32'd5, 32'd5, 32'd0, 1'b0, 1'b0, 0, 0, 1); drain(10);
    issue(OP_SLT,  32'hFFFFFFFF, 32'h1, 32'd1, 1'b0, 1'b0, 0, 0, 1); drain(10);
    issue(OP_SLTU, 32'hFFFFFFFF, 32'h1, 32'd0, 1'b0, 1'b0, 0, 0, 1); drain(10);
    issue(OP_AND,  32'hF0F01234, 32'h0FF0FFFF, 32'h00F01234, 1'b0, 1'b0, 0, 0, 1); drain(10);
    issue(OP_OR,   32'hF0F01234, 32'h0FF0FFFF, 32'hFFF0FFFF, 1'b0, 1'b0, 0, 0, 1); drain(10);
    issue(OP_XOR,  32'hF0F01234, 32'h0FF0FFFF, 32'hFF00EDCB, 1'b0, 1'b0, 0, 0, 1); drain(10);
    issue(OP_NOR,  32'hF0F01234, 32'h0FF0FFFF, 32'h000F0000, 1'b0, 1'b0, 0, 0, 1); drain(10);
    issue(OP_SUB,  32'h80000000, 32'h1, 32'h7FFFFFFF, 1'b1, 1'b0, 0, 0, 1); drain(10);
    issue(OP_ADD,  32'hFFFFFFFF, 32'h1, 32'd0, 1'b0, 1'b0, 0, 0, 1); drain(10);
    issue(4'b0011, 32'd5, 32'd5, 32'd0, 1'b0, 1'b0, 0, 0, 1); drain(10);

    // MULT with an ignored start pulse while busy
    issue(OP_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFEB, 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFEB, 34);
    repeat (3) @(negedge clk);
    #1; op = OP_ADD; din1 = 32'd1; din2 = 32'd1; start = 1'b1;
    @(negedge clk);
    chk("busy_mid_mult", 32'(busy), 32'd1);
    #1; start = 1'b0;
    drain(60);

    issue(OP_ADD,   32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 0, 0, 1); drain(10);
    issue(OP_DIV,   32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD, 34); drain(60);
    issue(OP_DIVU,  32'd7, 32'd0, 32'hFFFFFFFF, 1'b0, 1'b1, 32'd7, 32'hFFFFFFFF, 2); drain(60);
    issue(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b1, 32'd0, 32'h80000000, 34); drain(60);
    issue(OP_MULTU, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 1'b0, 1'b1, 32'd1, 32'hFFFFFFFE, 34); drain(60);
    issue(OP_DIVU,  32'd100, 32'd7, 32'd14, 1'b0, 1'b1, 32'd2, 32'd14, 34); drain(60);
    issue(OP_DIV,   32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 1'b1, 32'd1, 32'hFFFFFFFD, 34); drain(60);
    issue(OP_DIV,   32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, 1'b0, 1'b1, 32'hFFFFFFF9, 32'hFFFFFFFF, 2); drain(60);

    // Reset during CALC aborts without done
    @(negedge clk); #1;
    op = OP_MULT; din1 = 32'd3; din2 = 32'd3; start = 1'b1;
    @(negedge clk); #1; start = 1'b0;
    repeat (4) @(negedge clk);
    #1; rst = 1'b1;
    @(negedge clk);
    chk("abort_result", result_alu, 32'd0);
    chk("abort_ZF", 32'(ZF), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    #1; rst = 1'b0;
    exp_hi = '0; exp_lo = '0;
    dc = done_cnt;
    repeat (40) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt - dc), 32'd0);
    issue(OP_MULTU, 32'd6, 32'd7, 32'd42, 1'b0, 1'b1, 32'd0, 32'd42, 34); drain(60);

    // WIDTH=8 instance
    issue8(OP_MULTU, 8'hFF, 8'hFF, 8'h01, 1'b0, 1'b1, 8'hFE, 8'h01, 10); drain(30);
    issue8(OP_ADD,   8'h7F, 8'h01, 8'h80, 1'b1, 1'b0, 8'h00, 8'h00, 1); drain(10);
    issue8(OP_DIV,   8'h80, 8'hFF, 8'h80, 1'b0, 1'b1, 8'h00, 8'h80, 10); drain(30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
